ace_snap_loader: RTL
====================

ACE_SNAP_LOADER -- requirements
Module: ace_snap_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h2000: RAM address of the first decoded byte.
REQ-002 Parameter TAIL_CYCLES, default 16: clk_sys cycles that loader_reset stays high after loading finishes.
REQ-003 clk_sys  in  1  system clock; the only clock.
REQ-004 reset_n  in  1  reset; synchronous, active-low.
REQ-005 mem_ce  in  1  RAM write slot strobe; a write is issued only in a cycle where mem_ce=1.
REQ-006 ioctl_download  in  1  snapshot download in progress.
REQ-007 ioctl_wr  in  1  one-cycle strobe; ioctl_dout is valid in that cycle.
REQ-008 ioctl_dout  in  8  file byte.
REQ-009 ioctl_wait  out  1  backpressure; upstream SHALL NOT strobe ioctl_wr while it is high.
REQ-010 loader_en  out  1  loader owns the RAM write port.
REQ-011 loader_reset  out  1  holds the CPU in reset.
REQ-012 loader_wr  out  1  one-cycle RAM write strobe.
REQ-013 loader_addr  out  16  RAM write address.
REQ-014 loader_data  out  8  RAM write data.
REQ-015 err  out  1  sticky error flag; cleared only at the start of the next download.

Function
REQ-016 States: IDLE, LIT, ESC, CNT, REP, STOP, TAIL.
- IDLE: waiting for a download.
- LIT: literal byte stream.
- ESC: an 0xED byte has been received.
- CNT: a repeat count has been latched.
- REP: emitting a repeated byte.
- STOP: end marker seen.
- TAIL: reset hold after loading.
REQ-017 IDLE -> LIT on ioctl_download rising. On this transition: address counter = BASE_ADDR, err cleared, loader_en=1, loader_reset=1.
REQ-018 In LIT, a non-0xED byte becomes a pending write. ioctl_wait=1 from the cycle after the strobe until the write is issued.
REQ-019 A pending write is issued at the first cycle with mem_ce=1:
- loader_wr=1 for exactly that cycle, with loader_addr = counter and loader_data = byte;
- counter increments by 1 in the same cycle.
REQ-020 Latency: a literal byte accepted with mem_ce already high is written on the next cycle.
REQ-021 LIT -> ESC on byte 0xED. ESC -> STOP on byte 0x00. ESC -> CNT on any other byte n; n is latched as the count.
REQ-022 CNT -> REP on the next byte b. In REP, ioctl_wait=1 and b is written n times, one write per mem_ce cycle. REP -> LIT after the n-th write.
REQ-023 STOP: all further ioctl_wr bytes are ignored and no writes are issued. ioctl_wait=0.
REQ-024 The address counter is 17 bits. A write with counter > 16'hFFFF is suppressed and sets err; decoding continues.
REQ-025 ioctl_wr while ioctl_wait=1: the byte is dropped and err is set.
REQ-026 ioctl_download falling: pending writes and the current REP run complete first, then the block enters TAIL.
- If the fall occurs in ESC or CNT, err is set and the block enters TAIL immediately.
REQ-027 TAIL: loader_en=0, loader_reset=1 for TAIL_CYCLES cycles, then -> IDLE with loader_reset=0.
REQ-028 ioctl_download rising while in TAIL restarts at LIT, per REQ-017.

Reset
REQ-029 reset_n=0 at a clock edge:
- state = IDLE;
- ioctl_wait, loader_en, loader_reset, loader_wr, err = 0;
- loader_addr = BASE_ADDR, loader_data = 0;
- any pending write or repeat run is discarded.
REQ-030 After reset_n returns high, a download already in progress is ignored until ioctl_download falls and rises again.

Configuration
REQ-031 Macro ACE_SNAP_RLE_EN.
- Defined: RLE decoding per REQ-021 to REQ-023.
- Undefined: states ESC, CNT, REP and STOP are absent. Every byte, including 0xED, is a literal written per REQ-018 and REQ-019.

Verification
REQ-032 mem_ce every cycle, download of bytes 11 22 33 -> writes 2000=11, 2001=22, 2002=33; after download falls, loader_reset high for 16 more cycles.
REQ-033 With RLE enabled, stream ED 04 AA 55 -> AA written at 2000..2003, then 55 at 2004; ioctl_wait high throughout the repeat.
REQ-034 Stream 01 ED 00 02 03 -> only 2000=01 written; STOP reached; err=0.
REQ-035 mem_ce one cycle in 8; ioctl_wr strobed while ioctl_wait=1 -> that byte is dropped, err=1, other bytes are written correctly.
REQ-036 reset_n low during a REP run of 200 -> the next cycle has all outputs at reset values and no further loader_wr.
REQ-037 With RLE disabled, stream ED 00 -> 2000=ED, 2001=00.

Source files
------------

// File: rtl/ace_snap_loader.sv
// ace_snap_loader: turns a downloaded snapshot byte stream into RAM writes and holds the CPU in reset.
// Define ACE_SNAP_RLE_EN to enable 0xED run-length decoding; otherwise every byte is a literal.
module ace_snap_loader #(
   parameter logic [15:0] BASE_ADDR   = 16'h2000,
   parameter int          TAIL_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        mem_ce,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic        loader_en,
   output logic        loader_reset,
   output logic        loader_wr,
   output logic [15:0] loader_addr,
   output logic [7:0]  loader_data,
   output logic        err
);
   localparam int            TW        = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
   localparam logic [TW-1:0] TAIL_LOAD = TW'(TAIL_CYCLES - 1);

`ifdef ACE_SNAP_RLE_EN
   localparam logic [7:0] ESC_BYTE = 8'hED;
   typedef enum logic [2:0] {IDLE, LIT, ESC, CNT, REP, STOP, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, LIT, TAIL} state_t;
`endif

   state_t        state, state_nx;
   logic          dl_q, dl_rise;
   logic          pend, pend_nx;
   logic [7:0]    wr_data, data_nx;
   logic [16:0]   addr_cnt, addr_nx;
   logic [TW-1:0] tail_cnt, tail_nx;
   logic          err_nx;
   logic          want, fire, take;
`ifdef ACE_SNAP_RLE_EN
   logic [7:0]    rep_cnt, rep_nx;
`endif

   // dl_q resets high so a download already running at reset release is not seen as a new start
   assign dl_rise = ioctl_download & ~dl_q;

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state    <= IDLE;
         dl_q     <= 1'b1;
         pend     <= 1'b0;
         wr_data  <= 8'h00;
         addr_cnt <= {1'b0, BASE_ADDR};
         tail_cnt <= '0;
         err      <= 1'b0;
`ifdef ACE_SNAP_RLE_EN
         rep_cnt  <= 8'h00;
`endif
      end else begin
         state    <= state_nx;
         dl_q     <= ioctl_download;
         pend     <= pend_nx;
         wr_data  <= data_nx;
         addr_cnt <= addr_nx;
         tail_cnt <= tail_nx;
         err      <= err_nx;
`ifdef ACE_SNAP_RLE_EN
         rep_cnt  <= rep_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      pend_nx  = pend;
      data_nx  = wr_data;
      addr_nx  = addr_cnt;
      tail_nx  = tail_cnt;
      err_nx   = err;
`ifdef ACE_SNAP_RLE_EN
      rep_nx   = rep_cnt;
      want     = pend | (state == REP);
`else
      want     = pend;
`endif
      fire         = want & mem_ce;
      take         = ioctl_wr & ~want;
      ioctl_wait   = want;
      loader_wr    = fire & ~addr_cnt[16];
      loader_en    = (state != IDLE) && (state != TAIL);
      loader_reset = (state != IDLE);
      loader_addr  = addr_cnt[15:0];
      loader_data  = wr_data;

      if (ioctl_wr && want) err_nx = 1'b1;
      // a write slot always consumes the pending byte; past 0xFFFF it is dropped and flagged
      if (fire) begin
         pend_nx = 1'b0;
         if (addr_cnt[16]) err_nx = 1'b1;
         else              addr_nx = addr_cnt + 17'd1;
      end

      case (state)
         IDLE, TAIL: begin
            if (dl_rise) begin
               state_nx = LIT;
               addr_nx  = {1'b0, BASE_ADDR};
               err_nx   = 1'b0;
               pend_nx  = 1'b0;
            end else if (state == TAIL) begin
               if (tail_cnt == '0) state_nx = IDLE;
               else                tail_nx  = tail_cnt - TW'(1);
            end
         end
         LIT: begin
            if (take) begin
`ifdef ACE_SNAP_RLE_EN
               if (ioctl_dout == ESC_BYTE) state_nx = ESC;
               else begin
                  pend_nx = 1'b1;
                  data_nx = ioctl_dout;
               end
`else
               pend_nx = 1'b1;
               data_nx = ioctl_dout;
`endif
            end else if (!ioctl_download && !pend) begin
               state_nx = TAIL;
               tail_nx  = TAIL_LOAD;
            end
         end
`ifdef ACE_SNAP_RLE_EN
         ESC: begin
            if (take) begin
               if (ioctl_dout == 8'h00) state_nx = STOP;
               else begin
                  rep_nx   = ioctl_dout;
                  state_nx = CNT;
               end
            end else if (!ioctl_download) begin
               err_nx   = 1'b1;
               state_nx = TAIL;
               tail_nx  = TAIL_LOAD;
            end
         end
         CNT: begin
            if (take) begin
               data_nx  = ioctl_dout;
               state_nx = REP;
            end else if (!ioctl_download) begin
               err_nx   = 1'b1;
               state_nx = TAIL;
               tail_nx  = TAIL_LOAD;
            end
         end
         REP: begin
            if (fire) begin
               rep_nx = rep_cnt - 8'd1;
               if (rep_cnt == 8'd1) state_nx = LIT;
            end
         end
         STOP: begin
            if (!ioctl_download) begin
               state_nx = TAIL;
               tail_nx  = TAIL_LOAD;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end
endmodule
